// File: rtl/vec_normalize.sv
// Sequential N-component vector normaliser: out_i = v_i * d / |v|.
// Bit-serial sum of squares, restoring square root and restoring divide.
module vec_normalize #(
  parameter int N       = 3,
  parameter int W       = 11,
  parameter int SCALE_W = 8,
  parameter int OUT_W   = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*W-1:0]       in_vec,
  input  logic [SCALE_W-1:0]   in_d,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*OUT_W-1:0]   out_vec,
  output logic                 out_zero
);

  localparam int SQ_W  = 2*W - 1 + $clog2(N);
  localparam int R_W   = (SQ_W + 1) / 2;
  localparam int NUM_W = W - 1 + SCALE_W + 1;
  localparam int A_W   = 2*R_W;
  localparam int IDX_W = $clog2(N);
  localparam int BC_W  = $clog2(NUM_W > R_W ? NUM_W : R_W);
  localparam int RM_W  = R_W + 2;
  localparam int OMAX  = 2**(OUT_W-1) - 1;

  typedef enum logic [2:0] {
    IDLE, SUMSQ, SQRT, DIV, DONE
  } state_t;

  state_t state, state_nx;

  logic [N*W-1:0]     vec_q;
  logic [SCALE_W-1:0] d_q;
  logic [A_W-1:0]     acc;
  logic [R_W-1:0]     root;
  logic [RM_W-1:0]    srem;
  logic [R_W:0]       drem;
  logic [NUM_W-2:0]   quo;
  logic [N*OUT_W-1:0] res;
  logic [IDX_W-1:0]   ci;
  logic [BC_W-1:0]    bc;

  logic signed [W-1:0] cur;
  logic [W-1:0]        cabs;
  logic [2*W-1:0]      sq;
  logic [A_W-1:0]      acc_sum;
  logic                last_idx;
  logic                last_root;
  logic                last_bit;
  logic                acc_zero;

  logic [RM_W+1:0]     rem_sh;
  logic [RM_W+1:0]     trial;
  logic [RM_W-1:0]     sdiff;
  logic                sge;

  logic [NUM_W-1:0]    num;
  logic                nbit;
  logic [R_W:0]        rem_base;
  logic [NUM_W-2:0]    q_base;
  logic [R_W+1:0]      dsh;
  logic [R_W+1:0]      dmag;
  logic [R_W:0]        ddiff;
  logic                dge;
  logic [R_W:0]        drem_nx;
  logic [NUM_W-1:0]    quo_nx;
  logic [NUM_W-1:0]    qc;
  logic [OUT_W-1:0]    qo;
  logic [OUT_W-1:0]    qs;
  logic [N*OUT_W-1:0]  res_nx;

  assign in_ready = (state == IDLE);

  always_comb begin
    cur       = vec_q[ci*W +: W];
    cabs      = cur[W-1] ? -cur : cur;
    sq        = cabs * cabs;
    acc_sum   = acc + A_W'(sq);
    last_idx  = (ci == IDX_W'(N-1));
    last_root = (bc == BC_W'(R_W-1));
    last_bit  = (bc == BC_W'(NUM_W-1));
    acc_zero  = (acc == '0) && (bc == '0);

    rem_sh = {srem, acc[A_W-1 -: 2]};
    trial  = {2'b00, root, 2'b01};
    sge    = (rem_sh >= trial);
    sdiff  = rem_sh[RM_W-1:0] - trial[RM_W-1:0];

    // dividend bits are pulled MSB-first straight from |v_i|*d
    num      = cabs * d_q;
    nbit     = num[BC_W'(NUM_W-1) - bc];
    rem_base = (bc == '0) ? '0 : drem;
    q_base   = (bc == '0) ? '0 : quo;
    dsh      = {rem_base, nbit};
    dmag     = {2'b00, root};
    dge      = (dsh >= dmag);
    ddiff    = dsh[R_W:0] - dmag[R_W:0];
    drem_nx  = dge ? ddiff : dsh[R_W:0];
    quo_nx   = {q_base, dge};

    qc = quo_nx;
    if (qc > NUM_W'(d_q))
      qc = NUM_W'(d_q);
    if (qc > NUM_W'(OMAX))
      qc = NUM_W'(OMAX);
    qo = qc[OUT_W-1:0];
    if (cur == '0)
      qs = '0;
    else if (cur[W-1])
      qs = -qo;
    else
      qs = qo;

    res_nx = res;
    res_nx[ci*OUT_W +: OUT_W] = qs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (in_valid) state_nx = SUMSQ;
      SUMSQ: if (last_idx) state_nx = SQRT;
      SQRT: begin
        if (acc_zero)
          state_nx = DONE;
        else if (last_root)
          state_nx = DIV;
      end
      DIV:   if (last_bit && last_idx) state_nx = DONE;
      DONE:  if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q     <= '0;
      d_q       <= '0;
      acc       <= '0;
      root      <= '0;
      srem      <= '0;
      drem      <= '0;
      quo       <= '0;
      res       <= '0;
      ci        <= '0;
      bc        <= '0;
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            vec_q <= in_vec;
            d_q   <= in_d;
            acc   <= '0;
            ci    <= '0;
            bc    <= '0;
          end
        end
        SUMSQ: begin
          acc  <= acc_sum;
          srem <= '0;
          root <= '0;
          bc   <= '0;
          ci   <= last_idx ? '0 : ci + 1'b1;
        end
        SQRT: begin
          // zero vector is detected on the first root step and bypasses all math
          if (acc_zero) begin
            out_vec  <= '0;
            out_zero <= 1'b1;
          end else begin
            srem <= sge ? sdiff : rem_sh[RM_W-1:0];
            root <= {root[R_W-2:0], sge};
            acc  <= acc << 2;
            bc   <= last_root ? '0 : bc + 1'b1;
          end
        end
        DIV: begin
          drem <= drem_nx;
          quo  <= quo_nx[NUM_W-2:0];
          res  <= res_nx;
          if (last_bit) begin
            bc <= '0;
            ci <= last_idx ? '0 : ci + 1'b1;
            if (last_idx) begin
              out_vec  <= res_nx;
              out_zero <= 1'b0;
            end
          end else begin
            bc <= bc + 1'b1;
          end
        end
        DONE: begin
          if (!out_valid)
            out_valid <= 1'b1;
          else if (out_ready)
            out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_normalize.sv
// Scoreboard bench for vec_normalize: directed vectors, backpressure,
// mid-operation reset and a modelled random sweep.
module tb_vec_normalize;

  localparam int N    = 3;
  localparam int W    = 11;
  localparam int SW   = 8;
  localparam int OW   = 11;
  localparam int VW   = N*W;
  localparam int L_NZ = 73;
  localparam int L_Z  = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  in_vec;
  logic [SW-1:0]   in_d;
  logic            out_valid;
  logic            out_ready;
  logic [N*OW-1:0] out_vec;
  logic            out_zero;

  vec_normalize #(.N(N), .W(W), .SCALE_W(SW), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*OW-1:0] vec;
    logic            zero;
    int              lat;
    int              acc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok,
                     input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int x0, input int x1, input int x2, input bit z);
    exp_t e;
    e.vec  = {OW'(x2), OW'(x1), OW'(x0)};
    e.zero = z;
    e.lat  = z ? L_Z : L_NZ;
    e.acc  = 0;
    return e;
  endfunction

  function automatic exp_t model(input int a, input int b, input int c, input int d);
    exp_t   e;
    longint s, m, q, av;
    int     v[3];
    v[0] = a; v[1] = b; v[2] = c;
    s = longint'(a)*a + longint'(b)*b + longint'(c)*c;
    e.vec  = '0;
    e.zero = (s == 0);
    e.lat  = (s == 0) ? L_Z : L_NZ;
    e.acc  = 0;
    if (s != 0) begin
      m = 0;
      while ((m+1)*(m+1) <= s) m++;
      for (int i = 0; i < N; i++) begin
        av = (v[i] < 0) ? -longint'(v[i]) : longint'(v[i]);
        q = (av * d) / m;
        if (q > d) q = d;
        if (q > 1023) q = 1023;
        if (v[i] < 0) q = -q;
        e.vec[i*OW +: OW] = OW'(q);
      end
    end
    return e;
  endfunction

  task automatic send(input int a, input int b, input int c, input int d,
                      input exp_t e, input bit push);
    int n;
    @(posedge clk); #2;
    in_vec   = {W'(c), W'(b), W'(a)};
    in_d     = SW'(d);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 1'b0, 0, 1);
    end else begin
      e.acc = cyc + 1;
      if (push) sbq.push_back(e);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    in_vec   = VW'({$urandom, $urandom});
    in_d     = SW'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) chk("drain_timeout", 1'b0, sbq.size(), 0);
  endtask

  exp_t mon_e;
  logic prev_v = 1'b0;
  bit   chk_low = 1'b0;
  int   rise_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v  = 1'b0;
      chk_low = 1'b0;
    end else begin
      if (chk_low) begin
        chk("valid_drop", out_valid == 1'b0, out_valid, 0);
        chk_low = 1'b0;
      end
      if (out_valid && !prev_v) begin
        rise_cyc = cyc;
        if (sbq.size() == 0) chk("spurious_out", 1'b0, out_vec, 0);
      end
      if (out_valid && out_ready && sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("out_vec", out_vec == mon_e.vec, out_vec, mon_e.vec);
        chk("out_zero", out_zero == mon_e.zero, out_zero, mon_e.zero);
        chk("latency", (rise_cyc - mon_e.acc) == mon_e.lat,
            rise_cyc - mon_e.acc, mon_e.lat);
        chk_low = 1'b1;
      end
      prev_v = out_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*OW-1:0] bp_exp;
    exp_t e;
    int   n, a, b, c, d;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    in_d      = '0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready == 1'b1, in_ready, 1);
    chk("rst_out_valid", out_valid == 1'b0, out_valid, 0);
    chk("rst_out_vec", out_vec == '0, out_vec, 0);
    chk("rst_out_zero", out_zero == 1'b0, out_zero, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    send(3, 4, 0, 255, mk(153, 204, 0, 0), 1);
    send(-3, 4, 0, 255, mk(-153, 204, 0, 0), 1);
    send(-1024, 0, 0, 255, mk(-255, 0, 0, 0), 1);
    send(0, 0, 0, 200, mk(0, 0, 0, 1), 1);
    send(1, 1, 1, 255, mk(255, 255, 255, 0), 1);
    send(3, 4, 0, 0, mk(0, 0, 0, 0), 1);
    send(-1024, -1024, -1024, 255, mk(-147, -147, -147, 0), 1);
    send(1000, -1000, 500, 100, mk(66, -66, 33, 0), 1);
    send(0, 0, 1, 255, mk(0, 0, 255, 0), 1);
    send(0, -7, 0, 50, mk(0, -50, 0, 0), 1);
    drain();

    // backpressure: result must hold while downstream stalls
    @(posedge clk); #2 out_ready = 1'b0;
    bp_exp = {OW'(0), OW'(204), OW'(153)};
    send(3, 4, 0, 255, mk(153, 204, 0, 0), 1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", out_valid == 1'b1, out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold", out_valid && out_vec == bp_exp && !in_ready,
          {out_valid, in_ready, out_vec}, {2'b10, bp_exp});
      @(negedge clk);
    end
    @(posedge clk); #2 out_ready = 1'b1;
    drain();

    // reset in the middle of the divide phase
    send(5, 5, 5, 100, mk(0, 0, 0, 0), 0);
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid == 1'b0, out_valid, 0);
    chk("midrst_in_ready", in_ready == 1'b1, in_ready, 1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", in_ready == 1'b1, in_ready, 1);
    send(0, 5, 12, 13, mk(0, 5, 12, 0), 1);
    drain();

    for (int i = 0; i < 150; i++) begin
      if (i % 25 == 0) begin
        a = 0; b = 0; c = 0;
      end else if (i % 3 == 0) begin
        a = int'($urandom_range(16)) - 8;
        b = int'($urandom_range(16)) - 8;
        c = int'($urandom_range(16)) - 8;
      end else begin
        a = int'($urandom_range(2047)) - 1024;
        b = int'($urandom_range(2047)) - 1024;
        c = int'($urandom_range(2047)) - 1024;
      end
      d = int'($urandom_range(255));
      e = model(a, b, c, d);
      send(a, b, c, d, e, 1);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
